cic_interpolator: RTL and testbench

- Transmit-side counterpart to the receive-path CIC decimator.
- Accepts low-rate signed samples and raises the rate by INTERPOLATION using STAGES comb stages at the low rate, zero-stuffing, and STAGES integrators at the high rate.
- Sits between the TX baseband source and the DAC-rate upconversion path.
- Paces its source with a request pulse and flags underflow.

---
 rtl/cic_pkg.sv | 37 +++
 rtl/cic_interp_comb.sv | 31 +++
 rtl/cic_interpolator.sv | 131 +++++++++++++
 tb/tb_cic_interpolator.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the CIC interpolator.
// Holds the log2 helper, the accumulator width check and the output clamp.
package cic_pkg;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >>> 1;
    end
    return result;
  endfunction

  localparam int INTERPOLATION_DEF = 16;
  localparam int LOG2R             = clog2(INTERPOLATION_DEF);

  // Bit growth of an N-stage CIC with rate R is N*log2(R) above the input width.
  function automatic bit width_ok(input int acc_width, input int in_width,
                                  input int stages, input int log2r);
    return acc_width >= in_width + stages * log2r;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int out_width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
  endfunction

endpackage

// File: rtl/cic_interp_comb.sv
// One comb stage: out = in - in_delayed, delay advancing only when enabled.
module cic_interp_comb
  import cic_pkg::*;
#(
  parameter int WIDTH = 30
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] comb_in,
  output logic signed [WIDTH-1:0] comb_out
);

  logic signed [WIDTH-1:0] delay_q;
  logic signed [WIDTH-1:0] delay_d;

  // NOTE: default assignment first so every path drives delay_d and no latch is inferred.
  always_comb begin
    delay_d = delay_q;
    if (enable) delay_d = comb_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) delay_q <= '0;
    else       delay_q <= delay_d;
  end

  assign comb_out = comb_in - delay_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate comb chain, zero-stuffing, high-rate integrators.
// Define CIC_INTERP_SAT_EN to clamp the output instead of letting it wrap.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int STAGES        = 3,
  parameter int INTERPOLATION = 16,
  parameter int IN_WIDTH      = 18,
  parameter int ACC_WIDTH     = IN_WIDTH + 12,
  parameter int SHIFT         = 8,
  parameter int OUT_WIDTH     = IN_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rate_strobe,
  output logic                        in_req,
  input  logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        underflow
);

  localparam int PHASE_W = clog2(INTERPOLATION);
  localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(INTERPOLATION - 1);
  localparam logic [PHASE_W-1:0] PHASE_STUFF = PHASE_W'(1);

  if (!width_ok(ACC_WIDTH, IN_WIDTH, STAGES, PHASE_W)) begin : g_width_check
    $error("cic_interpolator: ACC_WIDTH too narrow for the CIC bit growth");
  end

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [PHASE_W-1:0]          phase_q, phase_d;
  logic signed [IN_WIDTH-1:0]  hold_q, hold_d;
  logic                        hold_valid_q, hold_valid_d;
  logic                        armed_q, armed_d;
  logic                        underflow_q, underflow_d;
  acc_t                        stuff_q, stuff_d;
  acc_t                        integ_q [STAGES];
  acc_t                        integ_d [STAGES];
  logic                        out_strobe_q, out_strobe_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  acc_t                        comb_sig [STAGES+1];
  acc_t                        last_integ;
  acc_t                        rounded;
  logic                        consume;

  assign consume     = rate_strobe && (phase_q == '0);
  assign comb_sig[0] = hold_valid_q ? acc_t'(hold_q) : '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    cic_interp_comb #(.WIDTH(ACC_WIDTH)) u_comb (
      .clock   (clock),
      .reset   (reset),
      .enable  (consume),
      .comb_in (comb_sig[k]),
      .comb_out(comb_sig[k+1])
    );
  end

  always_comb begin
    phase_d      = phase_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    armed_d      = armed_q;
    underflow_d  = underflow_q;
    stuff_d      = stuff_q;
    integ_d      = integ_q;
    out_strobe_d = rate_strobe;
    out_data_d   = out_data_q;
    last_integ   = integ_q[STAGES-1];
    rounded      = (last_integ >>> SHIFT) + acc_t'(last_integ[SHIFT-1]);

    if (rate_strobe) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      // The comb result registered at the consume tick enters on the following tick only.
      integ_d[0] = integ_q[0] + ((phase_q == PHASE_STUFF) ? stuff_q : '0);
      for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
`ifdef CIC_INTERP_SAT_EN
      out_data_d = OUT_WIDTH'(saturate(64'(rounded), OUT_WIDTH));
`else
      out_data_d = OUT_WIDTH'(rounded);
`endif
    end

    if (consume) begin
      stuff_d      = comb_sig[STAGES];
      hold_valid_d = 1'b0;
      if (!hold_valid_q && armed_q) underflow_d = 1'b1;
    end

    // A coincident new sample lands after the consume has taken the old one.
    if (in_strobe) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
      armed_d      = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      armed_q      <= 1'b0;
      underflow_q  <= 1'b0;
      stuff_q      <= '0;
      // NOTE: the integrator array is real state that must start at zero, so it is reset like any flop.
      integ_q      <= '{default: '0};
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      armed_q      <= armed_d;
      underflow_q  <= underflow_d;
      stuff_q      <= stuff_d;
      integ_q      <= integ_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
    end
  end

  assign in_req     = !reset && rate_strobe && (phase_q == PHASE_LAST);
  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator: DC vector table, directed corner sequences,
// and random stimulus compared against a convolution model of the CIC response.
module tb_cic_interpolator;

  localparam int STAGES = 3;
  localparam int R      = 16;
  localparam int IN_W   = 18;
  localparam int ACC_W  = IN_W + 12;
  localparam int SHIFT  = 8;
  localparam int OUT_W  = IN_W;
  localparam int HLEN   = STAGES * (R - 1) + 1;
  localparam int LAT    = STAGES + 1;
  localparam int MAXT   = 1024;

  typedef struct {
    longint dc_in;
    longint settled_out;
  } dc_vec_t;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    rate_strobe;
  logic                    in_req;
  logic                    in_strobe;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_strobe;
  logic signed [OUT_W-1:0] out_data;
  logic                    underflow;

  always #5 clock = ~clock;

  cic_interpolator #(
    .STAGES(STAGES), .INTERPOLATION(R), .IN_WIDTH(IN_W),
    .ACC_WIDTH(ACC_W), .SHIFT(SHIFT), .OUT_WIDTH(OUT_W)
  ) dut (
    .clock(clock), .reset(reset), .rate_strobe(rate_strobe), .in_req(in_req),
    .in_strobe(in_strobe), .in_data(in_data), .out_strobe(out_strobe),
    .out_data(out_data), .underflow(underflow)
  );

  int checks   = 0;
  int failures = 0;

  longint h [HLEN];
  longint u [MAXT];
  int     tick;
  bit     m_hv, m_armed, m_uf;
  longint m_hold;

  int     mode;
  longint dc_val;
  int     req_cnt, skip_req, coin_req;
  bit     coin_pending;
  longint coin_val;
  longint last_out;
  longint out_sum;

  dc_vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at tick %0d: got %0d expected %0d", name, tick, act, exp);
    end
  endtask

  // Impulse response of N cascaded length-R boxcars.
  task automatic build_h();
    longint tmp [HLEN];
    foreach (h[k]) h[k] = 0;
    h[0] = 1;
    for (int s = 0; s < STAGES; s++) begin
      foreach (tmp[k]) tmp[k] = 0;
      for (int k = 0; k < HLEN; k++)
        for (int j = 0; j < R; j++)
          if (k + j < HLEN) tmp[k+j] += h[k];
      h = tmp;
    end
  endtask

  function automatic longint model_out(input int n);
    longint acc;
    longint r;
    longint acc_mod;
    longint out_mod;
    acc     = 0;
    acc_mod = longint'(1) << ACC_W;
    out_mod = longint'(1) << OUT_W;
    for (int k = 0; k < HLEN; k++)
      if (n - LAT - k >= 0) acc += h[k] * u[n - LAT - k];
    acc = acc & (acc_mod - 1);
    if (acc >= acc_mod / 2) acc -= acc_mod;
    r = (acc >>> SHIFT) + ((acc >>> (SHIFT - 1)) & 1);
`ifdef CIC_INTERP_SAT_EN
    if (r > out_mod / 2 - 1) r = out_mod / 2 - 1;
    if (r < -(out_mod / 2))  r = -(out_mod / 2);
`else
    r = r & (out_mod - 1);
    if (r >= out_mod / 2) r -= out_mod;
`endif
    return r;
  endfunction

  task automatic model_reset();
    foreach (u[k]) u[k] = 0;
    tick = 0; m_hv = 0; m_armed = 0; m_uf = 0; m_hold = 0;
    req_cnt = 0; skip_req = -1; coin_req = -1; coin_pending = 0; coin_val = 0;
    last_out = 0; out_sum = 0;
  endtask

  // Called at a negedge; rate_strobe asserted during reset must have no effect.
  task automatic do_reset(input int cycles);
    reset = 1'b1; rate_strobe = 1'b1; in_strobe = 1'b0; in_data = '0;
    #1;
    check("reset_in_req", in_req, 0);
    @(negedge clock);
    check("reset_out_strobe", out_strobe, 0);
    check("reset_out_data", out_data, 0);
    check("reset_underflow", underflow, 0);
    repeat (cycles - 1) @(negedge clock);
    reset = 1'b0; rate_strobe = 1'b0;
    model_reset();
  endtask

  task automatic pick_sample(output longint v, output bit sup);
    logic signed [IN_W-1:0] rv;
    sup = (req_cnt != skip_req);
    v   = 0;
    case (mode)
      0: sup = 1'b0;
      1: v = dc_val;
      2: begin rv = IN_W'($urandom); v = rv; end
      3: v = (req_cnt == 0) ? dc_val : 0;
      4: v = req_cnt[0] ? -131072 : 131071;
      default: v = 0;
    endcase
    if (req_cnt == coin_req) begin
      coin_pending = 1'b1;
      rv = IN_W'($urandom);
      coin_val = rv;
    end
    req_cnt++;
  endtask

  task automatic do_tick(output bit req);
    rate_strobe = 1'b1;
    if (coin_pending) begin in_strobe = 1'b1; in_data = IN_W'(coin_val); end
    #1;
    req = ((tick % R) == R - 1);
    check("in_req", in_req, longint'(req));
    if (tick % R == 0) begin
      u[tick] = m_hv ? m_hold : 0;
      if (!m_hv && m_armed) m_uf = 1'b1;
      m_hv = 1'b0;
    end
    if (coin_pending) begin
      m_hold = coin_val; m_hv = 1'b1; m_armed = 1'b1; coin_pending = 1'b0;
    end
    @(negedge clock);
    rate_strobe = 1'b0; in_strobe = 1'b0;
    check("out_strobe_tick", out_strobe, 1);
    last_out = model_out(tick);
    check("out_data", out_data, last_out);
    out_sum += longint'(out_data);
    check("underflow", underflow, longint'(m_uf));
    tick++;
  endtask

  task automatic idle(input bit sup, input longint v);
    if (sup) begin
      in_strobe = 1'b1; in_data = IN_W'(v);
      m_hold = v; m_hv = 1'b1; m_armed = 1'b1;
    end
    #1;
    check("in_req_idle", in_req, 0);
    @(negedge clock);
    in_strobe = 1'b0;
    check("out_strobe_idle", out_strobe, 0);
  endtask

  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      bit     req;
      bit     sup;
      longint v;
      do_tick(req);
      sup = 1'b0; v = 0;
      if (req) pick_sample(v, sup);
      idle(sup, v);
      idle(1'b0, 0);
      idle(1'b0, 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rate_strobe = 1'b0; in_strobe = 1'b0; in_data = '0;
    build_h();
    vecs[0] = '{dc_in: 1000,    settled_out: 1000};
    vecs[1] = '{dc_in: -1000,   settled_out: -1000};
    vecs[2] = '{dc_in: 0,       settled_out: 0};
    vecs[3] = '{dc_in: 1,       settled_out: 1};
    vecs[4] = '{dc_in: -1,      settled_out: -1};
    vecs[5] = '{dc_in: 131071,  settled_out: 131071};
    vecs[6] = '{dc_in: -131072, settled_out: -131072};
    @(negedge clock);

    // Idle source: request cadence, silent zeros before any sample.
    do_reset(2);
    mode = 0;
    run_ticks(40);

    // DC table.
    for (int i = 0; i < $size(vecs); i++) begin
      do_reset(2);
      mode = 1; dc_val = vecs[i].dc_in;
      run_ticks(8 * R);
      check("dc_settled", out_data, vecs[i].settled_out);
      check("dc_no_underflow", underflow, 0);
    end

    // Impulse of 2^SHIFT: outputs are the raw taps, summing to R^STAGES.
    do_reset(2);
    mode = 3; dc_val = 256;
    run_ticks(6 * R);
    check("impulse_sum", out_sum, longint'(R) ** STAGES);

    // Withheld fifth sample: underflow rises at that consume and sticks.
    do_reset(2);
    mode = 1; dc_val = 500; skip_req = 4;
    run_ticks(5 * R);
    check("underflow_before_gap", underflow, 0);
    run_ticks(3 * R);
    check("underflow_sticky", underflow, 1);

    // Random data with a sample strobed in the same clock as a consume.
    do_reset(2);
    mode = 2; coin_req = 3;
    run_ticks(10 * R);
    check("coincident_no_underflow", underflow, 0);

    // Alternating full-scale samples.
    do_reset(2);
    mode = 4;
    run_ticks(8 * R);

    // Reset mid-stream, then a cold-start DC run must match the zero-state model.
    do_reset(2);
    mode = 2;
    run_ticks(37);
    do_reset(1);
    mode = 1; dc_val = 1000;
    run_ticks(6 * R);
    check("post_reset_dc", out_data, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
